reg_spill: RTL and testbench
============================

REG_SPILL -- requirements
Module: reg_spill

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of 8-bit registers addressable.
REQ-002 SHALL have ports (name direction width meaning):
  clk  in  1  clock, all state on rising edge
  reset  in  1  synchronous, active-low reset
  save_start  in  1  pulse: spill registers first_reg..last_reg to out stream
  restore_start  in  1  pulse: refill registers from in stream
  first_reg  in  5  lowest register index, sampled on accepted start
  last_reg  in  5  highest register index, sampled on accepted start
  busy  out  1  operation in progress
  done  out  1  one-cycle completion pulse
  rf_b  out  6  regfile byte read address, bit 5 always 0
  rf_Rb  in  8  regfile read data, valid one cycle after rf_b
  rf_write  out  1  regfile write strobe
  rf_write_word  out  1  always 0 (byte writes only)
  rf_d  out  6  regfile write address, bit 5 always 0
  rf_Rd  out  16  write data, {8'h00, byte}
  out_valid / out_ready / out_data  out/in/out  1/1/8  spill byte stream
  in_valid / in_ready / in_data  in/out/in  1/1/8  refill byte stream

Function
REQ-003 SHALL implement states IDLE, SAVE, DRAIN, RESTORE; busy=1 in all but IDLE.
REQ-004 In IDLE, save_start SHALL latch range and enter SAVE; restore_start SHALL latch range and enter RESTORE; both high: save wins.
REQ-005 Starts while busy SHALL be ignored.
REQ-006 If sampled first_reg > last_reg, state SHALL stay IDLE and done SHALL pulse the next cycle with no stream or regfile activity.
REQ-007 SAVE SHALL issue reads ascending first_reg..last_reg on rf_b, one per cycle when permitted.
REQ-008 Read data SHALL be captured from rf_Rb one cycle after issue into a 2-entry output FIFO.
REQ-009 A read SHALL issue only when FIFO occupancy plus in-flight reads < 2; no byte lost or duplicated under any out_ready pattern.
REQ-010 With out_ready held 1, SAVE SHALL sustain one byte per cycle after 1-cycle initial latency.
REQ-011 out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid && out_ready.
REQ-012 After the last read issues, state SHALL be DRAIN until FIFO empty and nothing in flight; then done pulses one cycle and state returns to IDLE.
REQ-013 RESTORE SHALL write descending last_reg..first_reg (stack order, inverse of SAVE).
REQ-014 in_ready SHALL equal (state==RESTORE); rf_write = in_valid && in_ready, combinational.
REQ-015 On write: rf_d = {1'b0, index}, rf_Rd = {8'h00, in_data}; index decrements per handshake.
REQ-016 Write at index first_reg SHALL end RESTORE; done pulses the next cycle; state IDLE.
REQ-017 rf_write SHALL never assert outside RESTORE; out_valid never asserts in IDLE or RESTORE.
REQ-018 Index counter SHALL not wrap: first_reg=0 restore terminates without decrementing below 0.

Reset
REQ-019 reset=0 at a clock edge SHALL force IDLE, empty FIFO, clear in-flight flag, busy=0, done=0, rf_write=0, out_valid=0, in_ready=0, rf_b=0, rf_d=0.
REQ-020 Reset mid-operation SHALL abort without done pulse; partial stream data is discarded.

Structure
REQ-021 State encodings and NUM_REGS default SHALL live in a shared guarded header included by CPU and spill logic.
REQ-022 The output FIFO SHALL be a sub-module byte_fifo2 (2-entry, valid/ready, synchronous active-low reset).

Verification
REQ-023 Bench SHALL model the regfile with 1-cycle read latency; scenarios:
  - Regs r0..r3=11,22,33,44; save 0..3, out_ready=1 -> out bytes 11,22,33,44 on 4 consecutive cycles, done 1 cycle after last.
  - Same save with out_ready toggling 1,0,0,1... -> same 4 bytes in order, none duplicated, done after 4th pop.
  - Restore 16..18, in bytes AA,BB,CC -> r18=AA, r17=BB, r16=CC, rf_write_word=0, done once.
  - Save 16..18 then restore 16..18 from captured stream -> regfile unchanged.
  - first_reg=5, last_reg=4 -> done next cycle, no out_valid, no rf_write.
  - reset=0 mid-save after 2 bytes -> next cycle busy=0, out_valid=0, no done; save_start then restarts cleanly.

Source files
------------

// File: rtl/reg_spill_pkg.sv
// Shared definitions for the register spill/refill engine: state encoding
// and the default register-file depth, used by the CPU side and the spill logic.
`ifndef REG_SPILL_PKG_SV
`define REG_SPILL_PKG_SV
package reg_spill_pkg;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int IDX_W            = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RESTORE = 2'd3
  } spill_state_e;

endpackage
`endif

// File: rtl/reg_spill_fifo.sv
// Two-entry byte FIFO with valid/ready on both sides. It buffers register
// read data between the regfile read port and the spill byte stream.
module byte_fifo2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] count
);

  logic [7:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic       push;
  logic       pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = cnt_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer and occupancy tracking; cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage is data only; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/reg_spill.sv
// Register spill/refill engine. SAVE streams regfile bytes first..last out
// through a 2-entry FIFO; RESTORE writes an incoming byte stream back in
// descending order (last..first) so a saved stream, replayed in reverse,
// puts every register back where it came from.
module reg_spill
  import reg_spill_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        save_start,
  input  logic        restore_start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  output logic        busy,
  output logic        done,
  output logic [5:0]  rf_b,
  input  logic [7:0]  rf_Rb,
  output logic        rf_write,
  output logic        rf_write_word,
  output logic [5:0]  rf_d,
  output logic [15:0] rf_Rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data
);

  spill_state_e     state_q, state_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             inflight_q, inflight_d;
  logic             done_q, done_d;

  logic             issue;
  logic             range_bad;
  logic             fifo_in_ready;
  logic             fifo_pop;
  logic [1:0]       fifo_cnt;
  logic [1:0]       occ_after;

  byte_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_q),
    .in_ready  (fifo_in_ready),
    .in_data   (rf_Rb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (fifo_cnt)
  );

  assign fifo_pop  = out_valid && out_ready;
  // Bytes held or owed to the FIFO once this cycle's pop is accounted for;
  // counting the pop lets a read issue every cycle while the sink keeps up.
  assign occ_after = fifo_cnt + {1'b0, inflight_q} - {1'b0, fifo_pop};
  assign range_bad = (first_reg > last_reg) || (int'(last_reg) >= NUM_REGS);

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign in_ready      = (state_q == ST_RESTORE);
  assign rf_write      = in_valid && in_ready;
  assign rf_write_word = 1'b0;
  assign rf_b          = issue ? {1'b0, idx_q} : 6'd0;
  assign rf_d          = in_ready ? {1'b0, idx_q} : 6'd0;
  assign rf_Rd         = {8'h00, in_data};

  // Control registers; range and index are plain data and need no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  // Range latch and walking register index.
  always_ff @(posedge clk) begin
    first_q <= first_d;
    last_q  <= last_d;
    idx_q   <= idx_d;
  end

  // Next-state, read issue and completion logic.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    last_d     = last_q;
    idx_d      = idx_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (save_start || restore_start) begin
          first_d = first_reg;
          last_d  = last_reg;
          if (range_bad) begin
            done_d = 1'b1;
          end else if (save_start) begin
            state_d = ST_SAVE;
            idx_d   = first_reg;
          end else begin
            state_d = ST_RESTORE;
            idx_d   = last_reg;
          end
        end
      end
      ST_SAVE: begin
        if ((occ_after < 2'd2) && (fifo_in_ready || fifo_pop)) begin
          issue      = 1'b1;
          inflight_d = 1'b1;
          if (idx_q == last_q) state_d = ST_DRAIN;
          else                 idx_d   = idx_q + 5'd1;
        end
      end
      ST_DRAIN: begin
        if (occ_after == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_RESTORE: begin
        if (rf_write) begin
          if (idx_q == first_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q - 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_spill.sv
// Directed bench for reg_spill: regfile model with one-cycle read latency,
// a stream/regfile scoreboard checked every cycle, and literal expectations.
module tb_reg_spill;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_start, restore_start;
  logic [4:0]  first_reg, last_reg;
  logic        busy, done;
  logic [5:0]  rf_b;
  logic [7:0]  rf_Rb;
  logic        rf_write, rf_write_word;
  logic [5:0]  rf_d;
  logic [15:0] rf_Rd;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;

  always #5 clk = ~clk;

  reg_spill dut (
    .clk(clk), .reset(reset), .save_start(save_start), .restore_start(restore_start),
    .first_reg(first_reg), .last_reg(last_reg), .busy(busy), .done(done),
    .rf_b(rf_b), .rf_Rb(rf_Rb), .rf_write(rf_write), .rf_write_word(rf_write_word),
    .rf_d(rf_d), .rf_Rd(rf_Rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready is either held high or follows the repeating pattern 1,0,0,1
  logic       rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;
  assign out_ready = rdy_mode ? rdy_pat[cyc[1:0]] : 1'b1;

  // Regfile model: registered read (one-cycle latency), byte writes, preload port
  logic [7:0] regs [32];
  logic       pre_we = 1'b0;
  logic [4:0] pre_addr = 5'd0;
  logic [7:0] pre_data = 8'd0;
  always @(posedge clk) begin
    rf_Rb <= regs[rf_b[4:0]];
    if (rf_write) regs[rf_d[4:0]] <= rf_Rd[7:0];
    else if (pre_we) regs[pre_addr] <= pre_data;
  end

  // Scoreboard state
  int         n_cmp = 0, n_fail = 0;
  logic [7:0] model_rf [32];
  logic [7:0] exp_q [$];
  int         addr_q [$];
  logic [7:0] cap_q [$];
  int         pop_cyc [$];
  logic [7:0] feed_q [$];
  int         done_cnt = 0, done_cyc = 0, ov_cnt = 0, wr_cnt = 0;
  int         start_cyc = 0;
  int         mon_a;
  logic       mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the high-level model
  always @(negedge clk) begin
    if (mon_en && reset) begin
      check("rf_write_handshake", 32'(rf_write), 32'(in_valid && in_ready));
      if (out_valid) begin
        ov_cnt++;
        check("out_valid_when_idle_or_restore", 32'(busy && !in_ready), 32'd1);
      end
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        cap_q.push_back(out_data);
        if (exp_q.size() == 0) check("unexpected_out_byte", 32'(out_data), 32'hFFFF_FFFF);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (rf_write) begin
        wr_cnt++;
        check("rf_write_word", 32'(rf_write_word), 32'd0);
        if (addr_q.size() == 0) check("unexpected_rf_write", 32'(rf_d), 32'hFFFF_FFFF);
        else begin
          mon_a = addr_q.pop_front();
          check("rf_d", 32'(rf_d), 32'(mon_a));
          check("rf_Rd", 32'(rf_Rd), {24'd0, in_data});
          model_rf[mon_a] = in_data;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_with_work_left", 32'(exp_q.size() + addr_q.size()), 32'd0);
      end
    end
  end

  task automatic preload(input int a, input logic [7:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = 5'(a); pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    model_rf[a] = d;
  endtask

  // One-cycle start pulse from IDLE; the model records the expected work.
  task automatic start_op(input logic sv, input logic rs, input int f, input int l);
    @(posedge clk); #1;
    save_start = sv; restore_start = rs;
    first_reg = 5'(f); last_reg = 5'(l);
    start_cyc = cyc;
    if (f <= l) begin
      if (sv) for (int i = f; i <= l; i++) exp_q.push_back(model_rf[i]);
      else if (rs) for (int i = l; i >= f; i--) addr_q.push_back(i);
    end
    @(posedge clk); #1;
    save_start = 1'b0; restore_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(done_cnt - d0), 32'd1);
  endtask

  // Feed feed_q on the refill stream; gap inserts an idle cycle between bytes.
  task automatic feed(input logic gap);
    int n;
    for (int k = 0; k < feed_q.size(); k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = feed_q[k];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("in_ready_timeout", 32'(n < 50), 32'd1);
      if (gap) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0, w0;
    reset = 1'b0; save_start = 1'b0; restore_start = 1'b0;
    first_reg = 5'd0; last_reg = 5'd0; in_valid = 1'b0; in_data = 8'd0;
    for (int i = 0; i < 32; i++) model_rf[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_rf_write", 32'(rf_write), 32'd0);
    check("reset_rf_b", 32'(rf_b), 32'd0);
    check("reset_rf_d", 32'(rf_d), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 32; i++) preload(i, 8'(8'h80 + i));
    preload(0, 8'h11); preload(1, 8'h22); preload(2, 8'h33); preload(3, 8'h44);

    // Save 0..3, sink always ready, both starts high (save wins)
    cap_q.delete(); pop_cyc.delete(); d0 = done_cnt; w0 = wr_cnt;
    start_op(1'b1, 1'b1, 0, 3);
    wait_done(d0, "s1_done");
    check("s1_bytes", 32'(cap_q.size()), 32'd4);
    check("s1_no_write", 32'(wr_cnt - w0), 32'd0);
    if (cap_q.size() == 4) begin
      check("s1_b0", 32'(cap_q[0]), 32'h11);
      check("s1_b1", 32'(cap_q[1]), 32'h22);
      check("s1_b2", 32'(cap_q[2]), 32'h33);
      check("s1_b3", 32'(cap_q[3]), 32'h44);
      for (int i = 1; i < 4; i++) check("s1_consecutive", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
      check("s1_done_lat", 32'(done_cyc - pop_cyc[3]), 32'd1);
    end
    @(negedge clk);
    check("s1_idle", 32'(busy), 32'd0);

    // Same save with out_ready toggling; starts while busy must be ignored
    rdy_mode = 1'b1;
    cap_q.delete(); pop_cyc.delete(); d0 = done_cnt;
    start_op(1'b1, 1'b0, 0, 3);
    @(posedge clk); #1;
    restore_start = 1'b1; save_start = 1'b1; first_reg = 5'd16; last_reg = 5'd18;
    @(posedge clk); #1;
    restore_start = 1'b0; save_start = 1'b0;
    wait_done(d0, "s2_done");
    check("s2_bytes", 32'(cap_q.size()), 32'd4);
    if (cap_q.size() == 4) begin
      check("s2_b0", 32'(cap_q[0]), 32'h11);
      check("s2_b3", 32'(cap_q[3]), 32'h44);
      check("s2_done_lat", 32'(done_cyc - pop_cyc[3]), 32'd1);
    end
    rdy_mode = 1'b0;

    // Restore 16..18 from AA,BB,CC with idle gaps
    d0 = done_cnt;
    start_op(1'b0, 1'b1, 16, 18);
    feed_q.delete(); feed_q.push_back(8'hAA); feed_q.push_back(8'hBB); feed_q.push_back(8'hCC);
    feed(1'b1);
    wait_done(d0, "s3_done");
    repeat (3) @(negedge clk);
    check("s3_done_once", 32'(done_cnt - d0), 32'd1);
    check("s3_r18", 32'(regs[18]), 32'hAA);
    check("s3_r17", 32'(regs[17]), 32'hBB);
    check("s3_r16", 32'(regs[16]), 32'hCC);
    check("s3_idle", 32'(busy), 32'd0);

    // Save 16..18, clobber, then restore from the reversed capture
    cap_q.delete(); d0 = done_cnt;
    start_op(1'b1, 1'b0, 16, 18);
    wait_done(d0, "s4_save_done");
    check("s4_cap_len", 32'(cap_q.size()), 32'd3);
    preload(16, 8'h00); preload(17, 8'h00); preload(18, 8'h00);
    feed_q.delete();
    for (int i = cap_q.size() - 1; i >= 0; i--) feed_q.push_back(cap_q[i]);
    d0 = done_cnt;
    start_op(1'b0, 1'b1, 16, 18);
    feed(1'b0);
    wait_done(d0, "s4_restore_done");
    @(negedge clk);
    check("s4_r16", 32'(regs[16]), 32'hCC);
    check("s4_r17", 32'(regs[17]), 32'hBB);
    check("s4_r18", 32'(regs[18]), 32'hAA);

    // Empty range: done next cycle, no activity
    d0 = done_cnt; o0 = ov_cnt; w0 = wr_cnt;
    start_op(1'b1, 1'b0, 5, 4);
    wait_done(d0, "s5_done");
    check("s5_done_next", 32'(done_cyc - start_cyc), 32'd1);
    repeat (4) @(negedge clk);
    check("s5_no_out", 32'(ov_cnt - o0), 32'd0);
    check("s5_no_write", 32'(wr_cnt - w0), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);

    // Restore starting at register 0 must stop there
    d0 = done_cnt;
    start_op(1'b0, 1'b1, 0, 1);
    feed_q.delete(); feed_q.push_back(8'h5E); feed_q.push_back(8'h6F);
    feed(1'b0);
    wait_done(d0, "s6_done");
    repeat (2) @(negedge clk);
    check("s6_r1", 32'(regs[1]), 32'h5E);
    check("s6_r0", 32'(regs[0]), 32'h6F);
    check("s6_busy", 32'(busy), 32'd0);

    // Reset mid-save after two bytes, then restart cleanly
    cap_q.delete(); d0 = done_cnt;
    start_op(1'b1, 1'b0, 0, 3);
    begin
      int n = 0;
      while (cap_q.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
      check("s7_two_bytes", 32'(cap_q.size() >= 2), 32'd1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    check("s7_busy", 32'(busy), 32'd0);
    check("s7_out_valid", 32'(out_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("s7_no_done", 32'(done_cnt - d0), 32'd0);
    cap_q.delete(); d0 = done_cnt;
    start_op(1'b1, 1'b0, 0, 3);
    wait_done(d0, "s7_restart_done");
    check("s7_restart_len", 32'(cap_q.size()), 32'd4);
    if (cap_q.size() == 4) begin
      check("s7_b0", 32'(cap_q[0]), 32'h6F);
      check("s7_b2", 32'(cap_q[2]), 32'h33);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
